// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions for the sin_cos and atan2/magnitude blocks.
// Holds the arctangent table, the state encoding and the 1/K shift-add constants.
package cordic_pkg;

  localparam int G = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FOLD = 3'd1,
    ITER = 3'd2,
    GAIN = 3'd3,
    DONE = 3'd4
  } state_t;

  // 1/K ~= 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13, evaluated on a value pre-scaled by 2^GC_FRAC
  localparam int GC_FRAC = 13;
  localparam int GC_ADD0 = 1;
  localparam int GC_ADD1 = 3;
  localparam int GC_SUB0 = 6;
  localparam int GC_SUB1 = 9;
  localparam int GC_SUB2 = 13;

  // atan(2^-i) with a full turn of 2^32, rescaled to 2^(asize+g) LSB per quadrant, rounded
  function automatic longint atan_lut(input int i, input int asize, input int g);
    longint t;
    int     sh;
    case (i)
      0:       t = 64'd536870912;
      1:       t = 64'd316933406;
      2:       t = 64'd167458907;
      3:       t = 64'd85004756;
      4:       t = 64'd42667331;
      5:       t = 64'd21354465;
      6:       t = 64'd10679838;
      7:       t = 64'd5340245;
      8:       t = 64'd2670163;
      9:       t = 64'd1335087;
      10:      t = 64'd667544;
      11:      t = 64'd333772;
      12:      t = 64'd166886;
      13:      t = 64'd83443;
      14:      t = 64'd41722;
      default: t = 64'd41722 >> (i - 14);
    endcase
    sh = 30 - asize - g;
    if (sh > 0) atan_lut = (t + (longint'(1) <<< (sh - 1))) >>> sh;
    else        atan_lut = t <<< (-sh);
  endfunction

endpackage

// File: rtl/cordic_gain_comp.sv
// Combinational shift-add multiply by 1/K (~0.60725), truncated; the caller registers the result.
// Input is the non-negative CORDIC x accumulator; output has the same width.
module cordic_gain_comp
  import cordic_pkg::*;
#(
  parameter int XW = 10
) (
  input  logic [XW-1:0] mag_raw,
  output logic [XW-1:0] mag_comp
);

  localparam int EW = XW + GC_FRAC;

  logic [EW-1:0] ext;
  logic [EW-1:0] acc;

  // pre-scaling keeps every shifted term exact, so only the final drop truncates
  always_comb begin
    ext      = EW'(mag_raw) << GC_FRAC;
    acc      = (ext >> GC_ADD0) + (ext >> GC_ADD1)
             - (ext >> GC_SUB0) - (ext >> GC_SUB1) - (ext >> GC_SUB2);
    mag_comp = XW'(acc >> GC_FRAC);
  end

endmodule

// File: rtl/cordic_atan2_mag.sv
// Iterative vectoring CORDIC: (x,y) -> atan2 angle and magnitude, one micro-rotation per cycle; result RNUM+2 cycles after accept (RNUM+3 with CORDIC_GAIN_COMP_EN).
// in_ready only in IDLE; the result is held in DONE until out_ready, with no same-cycle input bypass.
module cordic_atan2_mag
  import cordic_pkg::*;
#(
  parameter int ASIZE = 8,
  parameter int DSIZE = 8,
  parameter int RNUM  = 8
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DSIZE-1:0]   x,
  input  logic [DSIZE-1:0]   y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ASIZE+1:0]   angle,
  output logic [DSIZE+1:0]   mag
);

  localparam int XW = DSIZE + 2;
  localparam int AW = ASIZE + 2;
  localparam int ZW = AW + G;
  localparam int IW = (RNUM > 1) ? $clog2(RNUM) : 1;

  localparam logic [IW-1:0] I_LAST = IW'(RNUM - 1);
  localparam logic [ZW-1:0] Z_PI   = {2'b10, {(ASIZE + G){1'b0}}};
  localparam logic [ZW-1:0] Z_HALF = ZW'(1 << (G - 1));

  state_t                state_q, state_d;
  logic signed [XW-1:0]  xr_q, xr_d;
  logic signed [XW-1:0]  yr_q, yr_d;
  logic [ZW-1:0]         z_q, z_d;
  logic [IW-1:0]         i_q, i_d;
  logic                  zero_q, zero_d;
  logic [AW-1:0]         angle_q, angle_d;
  logic [XW-1:0]         mag_q, mag_d;

  logic signed [XW-1:0]  xr_sh, yr_sh, xr_it, yr_it;
  logic [ZW-1:0]         atan_z, z_it, z_fin, z_rnd;
  logic [XW-1:0]         xr_fin;

`ifdef CORDIC_GAIN_COMP_EN
  logic [XW-1:0] gain_mag;

  cordic_gain_comp #(.XW(XW)) u_gain_comp (
    .mag_raw  (xr_q),
    .mag_comp (gain_mag)
  );
`endif

  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    z_d     = z_q;
    i_d     = i_q;
    zero_d  = zero_q;
    angle_d = angle_q;
    mag_d   = mag_q;

    // one micro-rotation toward y=0, both updates from pre-update values
    xr_sh  = xr_q >>> i_q;
    yr_sh  = yr_q >>> i_q;
    atan_z = ZW'(atan_lut(int'(i_q), ASIZE, G));
    if (!yr_q[XW-1]) begin
      xr_it = xr_q + yr_sh;
      yr_it = yr_q - xr_sh;
      z_it  = z_q + atan_z;
    end else begin
      xr_it = xr_q - yr_sh;
      yr_it = yr_q + xr_sh;
      z_it  = z_q - atan_z;
    end

`ifdef CORDIC_GAIN_COMP_EN
    z_fin  = z_q;
    xr_fin = gain_mag;
`else
    z_fin  = z_it;
    xr_fin = xr_it;
`endif
    z_rnd = z_fin + Z_HALF;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          xr_d    = {{2{x[DSIZE-1]}}, x};
          yr_d    = {{2{y[DSIZE-1]}}, y};
          zero_d  = (x == '0) && (y == '0);
          state_d = FOLD;
        end
      end
      FOLD: begin
        // left half-plane: rotate by 180 degrees so the iterations only cover +-90
        if (xr_q[XW-1]) begin
          xr_d = -xr_q;
          yr_d = -yr_q;
          z_d  = Z_PI;
        end else begin
          z_d = '0;
        end
        i_d     = '0;
        state_d = ITER;
      end
      ITER: begin
        xr_d = xr_it;
        yr_d = yr_it;
        z_d  = z_it;
        i_d  = i_q + 1'b1;
        if (i_q == I_LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d = GAIN;
`else
          angle_d = zero_q ? '0 : AW'(z_rnd >> G);
          mag_d   = zero_q ? '0 : xr_fin;
          state_d = DONE;
`endif
        end
      end
      GAIN: begin
`ifdef CORDIC_GAIN_COMP_EN
        angle_d = zero_q ? '0 : AW'(z_rnd >> G);
        mag_d   = zero_q ? '0 : xr_fin;
        state_d = DONE;
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= IDLE;
      xr_q    <= '0;
      yr_q    <= '0;
      z_q     <= '0;
      i_q     <= '0;
      zero_q  <= 1'b0;
      angle_q <= '0;
      mag_q   <= '0;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      z_q     <= z_d;
      i_q     <= i_d;
      zero_q  <= zero_d;
      angle_q <= angle_d;
      mag_q   <= mag_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign angle     = angle_q;
  assign mag       = mag_q;

endmodule

// File: tb/tb_cordic_atan2_mag.sv
// Directed-vector bench for cordic_atan2_mag at ASIZE=DSIZE=RNUM=8.
// Covers angle/magnitude per quadrant, zero input, output hold, and reset during iteration.
module tb_cordic_atan2_mag;

  localparam int ASIZE = 8;
  localparam int DSIZE = 8;
  localparam int RNUM  = 8;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = RNUM + 3;
  localparam bit GC  = 1'b1;
`else
  localparam int LAT = RNUM + 2;
  localparam bit GC  = 1'b0;
`endif

  logic               clock = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [DSIZE-1:0]   x;
  logic [DSIZE-1:0]   y;
  logic               out_valid;
  logic               out_ready;
  logic [ASIZE+1:0]   angle;
  logic [DSIZE+1:0]   mag;

  int n_cmp = 0;
  int n_bad = 0;

  cordic_atan2_mag #(.ASIZE(ASIZE), .DSIZE(DSIZE), .RNUM(RNUM)) dut (
    .clock     (clock),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .angle     (angle),
    .mag       (mag)
  );

  always #5 clock = ~clock;

  typedef struct {
    int vx;
    int vy;
    int ang;
    int mag_raw;
    int mag_comp;
    int mtol;
  } vec_t;

  vec_t vecs[10];

  task automatic check_int(input string name, input int act, input int exp, input int tol);
    int d;
    n_cmp++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (+/-%0d)", name, act, exp, tol);
    end
  endtask

  task automatic check_ang(input string name, input int act, input int exp);
    int d;
    n_cmp++;
    d = (act - exp) & 1023;
    if (d > 512) d = 1024 - d;
    if (d > 2) begin
      n_bad++;
      $display("FAIL %s: angle got %0d, want %0d (+/-2 mod 1024)", name, act, exp);
    end
  endtask

  // Presents one vector with out_ready high; returns the result and the cycle count
  // from the accepting cycle to the first cycle with out_valid.
  task automatic run_one(input int vx, input int vy, output int ang, output int mg,
                         output int lat, output bit ok);
    int c;
    @(negedge clock);
    x         = vx[DSIZE-1:0];
    y         = vy[DSIZE-1:0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    ok  = 1'b0;
    lat = 0;
    ang = 0;
    mg  = 0;
    c   = 0;
    while (!ok && c < 60) begin
      @(posedge clock);
      c++;
      @(negedge clock);
      in_valid = 1'b0;
      if (out_valid) begin
        ok  = 1'b1;
        lat = c;
        ang = int'(angle);
        mg  = int'(mag);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  a, m, l, hold_a, hold_m, stray, ok_cnt;
    bit  ok;

    vecs[0] = '{100,    0,    0, 165, 100, 2};
    vecs[1] = '{0,    100,  256, 165, 100, 3};
    vecs[2] = '{-100,   0,  512, 165, 100, 3};
    vecs[3] = '{0,   -100,  768, 165, 100, 3};
    vecs[4] = '{100,  100,  128, 233, 141, 3};
    vecs[5] = '{-128, -128, 640, 298, 181, 4};
    vecs[6] = '{0,      0,    0,   0,   0, 0};
    vecs[7] = '{100,   -1, 1022, 165, 100, 3};
    vecs[8] = '{-100, 100,  384, 233, 141, 4};
    vecs[9] = '{100, -100,  896, 233, 141, 4};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    y         = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    rst = 1'b0;
    check_int("reset_in_ready", int'(in_ready), 1, 0);
    check_int("reset_out_valid", int'(out_valid), 0, 0);
    check_int("reset_angle", int'(angle), 0, 0);
    check_int("reset_mag", int'(mag), 0, 0);

    for (int i = 0; i < 10; i++) begin
      run_one(vecs[i].vx, vecs[i].vy, a, m, l, ok);
      check_int($sformatf("vec%0d_done", i), int'(ok), 1, 0);
      if (ok) begin
        check_int($sformatf("vec%0d_latency", i), l, LAT, 0);
        if (vecs[i].vx == 0 && vecs[i].vy == 0) begin
          check_int($sformatf("vec%0d_angle_zero", i), a, 0, 0);
        end else begin
          check_ang($sformatf("vec%0d_angle", i), a, vecs[i].ang);
        end
        check_int($sformatf("vec%0d_mag", i), m,
                  GC ? vecs[i].mag_comp : vecs[i].mag_raw, vecs[i].mtol);
      end
    end

    // Backpressure: result held for 20 cycles, inputs refused meanwhile.
    @(negedge clock);
    x         = 8'd100;
    y         = 8'd100;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    ok        = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      ok = out_valid;
    end
    check_int("hold_reached_done", int'(ok), 1, 0);
    hold_a = int'(angle);
    hold_m = int'(mag);
    check_ang("hold_angle_value", hold_a, 128);
    check_int("hold_mag_value", hold_m, GC ? 141 : 233, 3);
    ok_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid = c[0];
      x        = 8'd5;
      y        = 8'd7;
      @(posedge clock);
      @(negedge clock);
      if (out_valid && !in_ready && int'(angle) == hold_a && int'(mag) == hold_m) ok_cnt++;
    end
    check_int("hold_stable_cycles", ok_cnt, 20, 0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    check_int("release_out_valid", int'(out_valid), 0, 0);
    check_int("release_in_ready_no_bypass", int'(in_ready), 1, 0);
    @(posedge clock);
    @(negedge clock);
    check_int("release_idle_stays", int'(in_ready), 1, 0);

    // Reset while iterating at i=4: abandons the work and clears the held result.
    check_int("pre_reset_angle_nonzero", int'(angle != '0), 1, 0);
    x         = 8'd100;
    y         = 8'd0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
    end
    check_int("mid_iter_index", int'(dut.i_q), 4, 0);
    check_int("mid_iter_busy", int'(in_ready), 0, 0);
    rst = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rst = 1'b0;
    check_int("midrst_in_ready", int'(in_ready), 1, 0);
    check_int("midrst_out_valid", int'(out_valid), 0, 0);
    check_int("midrst_angle", int'(angle), 0, 0);
    check_int("midrst_mag", int'(mag), 0, 0);
    stray = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (out_valid) stray++;
    end
    check_int("midrst_no_output", stray, 0, 0);
    run_one(0, 100, a, m, l, ok);
    check_int("post_rst_done", int'(ok), 1, 0);
    if (ok) begin
      check_ang("post_rst_angle", a, 256);
      check_int("post_rst_latency", l, LAT, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
